// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target engine.
package i2c_target_pkg;

    // Width of the bit counter inside one byte (0..7).
    localparam int BIT_CNT_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_STRETCH,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C line conditioning: 2-FF synchroniser and glitch filter on SCL/SDA,
// followed by registered SCL edge and START/STOP condition pulses.
// A pulse is high in the same cycle in which the filtered level takes its new value.
module i2c_bus_monitor #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

    // Bit 0 is SCL, bit 1 is SDA.
    logic [1:0] pad_in;
    logic [1:0] filt_q;
    logic [1:0] filt_d;

    assign pad_in = {sda_i, scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic       sync1_q;
            logic       sync2_q;
            logic       lvl_q;
            logic [3:0] cnt_q;
            logic       lvl_d;

            // Bring the pad into the clk domain; idle bus level is 1.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                end else begin
                    sync1_q <= pad_in[gi];
                    sync2_q <= sync1_q;
                end
            end

            // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
            always_comb begin
                lvl_d = lvl_q;
                if ((sync2_q != lvl_q) && (cnt_q == CNT_MAX)) begin
                    lvl_d = sync2_q;
                end
            end

            // Count consecutive samples that disagree with the filtered level.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    lvl_q <= 1'b1;
                    cnt_q <= 4'd0;
                end else begin
                    lvl_q <= lvl_d;
                    if ((sync2_q == lvl_q) || (cnt_q == CNT_MAX)) begin
                        cnt_q <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
            end

            assign filt_q[gi] = lvl_q;
            assign filt_d[gi] = lvl_d;
        end
    endgenerate

    // Edge and bus-condition pulses; START/STOP need SCL high before and after.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_rise  <= filt_d[0] & ~filt_q[0];
            scl_fall  <= ~filt_d[0] & filt_q[0];
            start_det <= filt_q[0] & filt_d[0] & filt_q[1] & ~filt_d[1];
            stop_det  <= filt_q[0] & filt_d[0] & ~filt_q[1] & filt_d[1];
        end
    end

    assign sda_f = filt_q[1];

endmodule

// File: rtl/i2c_target.sv
// 7-bit I2C target: address match, write bytes out on m_axis, read bytes in
// from s_axis, SCL stretching whenever the stream side is not ready.
module i2c_target
    import i2c_target_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       enable,
    input  logic [6:0] device_address,
    output logic [7:0] m_axis_data_tdata,
    output logic       m_axis_data_tvalid,
    input  logic       m_axis_data_tready,
    input  logic [7:0] s_axis_data_tdata,
    input  logic       s_axis_data_tvalid,
    output logic       s_axis_data_tready,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic       busy,
    output logic       bus_active,
    output logic       bus_addressed,
    output logic       last_rw
);

    logic sda_f, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_monitor #(
        .FILTER_LEN(FILTER_LEN)
    ) u_mon (
        .clk      (clk),
        .arst_n   (arst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 byte_done_q, byte_done_d;
    logic                 nack_q, nack_d;
    logic                 sda_t_q, sda_t_d;
    logic                 scl_t_q, scl_t_d;
    logic                 busy_q, busy_d;
    logic                 active_q, active_d;
    logic                 addressed_q, addressed_d;
    logic                 rw_q, rw_d;
    logic [7:0]           m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 rd_take;
    logic                 out_free;

    // State and output registers; every line is released by reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            nack_q      <= 1'b0;
            sda_t_q     <= 1'b1;
            scl_t_q     <= 1'b1;
            busy_q      <= 1'b0;
            active_q    <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            m_tdata_q   <= 8'h00;
            m_tvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            nack_q      <= nack_d;
            sda_t_q     <= sda_t_d;
            scl_t_q     <= scl_t_d;
            busy_q      <= busy_d;
            active_q    <= active_d;
            addressed_q <= addressed_d;
            rw_q        <= rw_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
        end
    end

    // Next-state logic; START/STOP override whatever the current state wants.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        nack_d      = nack_q;
        sda_t_d     = sda_t_q;
        scl_t_d     = scl_t_q;
        busy_d      = busy_q;
        active_d    = active_q;
        addressed_d = addressed_q;
        rw_d        = rw_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q & ~m_axis_data_tready;
        rd_take     = 1'b0;
        // The output register can take a new byte if empty or being drained now.
        out_free    = ~m_tvalid_q | m_axis_data_tready;

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            sda_t_d     = 1'b1;
            scl_t_d     = 1'b1;
            active_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            active_d = 1'b0;
            sda_t_d  = 1'b1;
            scl_t_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (enable && (shift_d[7:1] == device_address)) begin
                                state_d     = ST_ADDR_ACK;
                                busy_d      = 1'b1;
                                addressed_d = 1'b1;
                                rw_d        = shift_d[0];
                            end else begin
                                state_d     = ST_WAIT_STOP;
                                busy_d      = 1'b0;
                                addressed_d = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // First fall starts the ACK, second fall ends it.
                    if (scl_fall) begin
                        if (sda_t_q) begin
                            sda_t_d = 1'b0;
                        end else begin
                            sda_t_d     = 1'b1;
                            bit_cnt_d   = '0;
                            byte_done_d = 1'b0;
                            state_d     = rw_q ? ST_RD_LOAD : ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (out_free) begin
                            m_tdata_d  = shift_q;
                            m_tvalid_d = 1'b1;
                            sda_t_d    = 1'b0;
                            state_d    = ST_WR_ACK;
                        end else begin
                            scl_t_d = 1'b0;
                            state_d = ST_WR_STRETCH;
                        end
                    end
                end
                ST_WR_STRETCH: begin
                    if (out_free) begin
                        m_tdata_d  = shift_q;
                        m_tvalid_d = 1'b1;
                        scl_t_d    = 1'b1;
                        sda_t_d    = 1'b0;
                        state_d    = ST_WR_ACK;
                    end else begin
                        scl_t_d = 1'b0;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_t_d = 1'b1;
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    // SCL is low here; hold it until a byte is available.
                    if (s_axis_data_tvalid) begin
                        rd_take   = 1'b1;
                        shift_d   = s_axis_data_tdata;
                        sda_t_d   = s_axis_data_tdata[7];
                        scl_t_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                    end else begin
                        scl_t_d = 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_t_d   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_t_d   = shift_d[7];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_f;
                    end else if (scl_fall) begin
                        state_d = nack_q ? ST_WAIT_STOP : ST_RD_LOAD;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    sda_t_d = 1'b1;
                    scl_t_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    sda_t_d = 1'b1;
                    scl_t_d = 1'b1;
                end
            endcase
        end
    end

    assign scl_o              = 1'b0;
    assign sda_o              = 1'b0;
    assign scl_t              = scl_t_q;
    assign sda_t              = sda_t_q;
    assign busy               = busy_q;
    assign bus_active         = active_q;
    assign bus_addressed      = addressed_q;
    assign last_rw            = rw_q;
    assign m_axis_data_tdata  = m_tdata_q;
    assign m_axis_data_tvalid = m_tvalid_q;
    assign s_axis_data_tready = rd_take;

endmodule

// File: tb/tb_i2c_target.sv
// Directed plus randomized bench for i2c_target: a bit-level bus controller,
// stream source/sink and a transaction-level expectation model.
module tb_i2c_target;

    localparam int FL = 4;
    localparam int Q  = 20;   // quarter SCL period in clk cycles
    localparam logic [6:0] DEV = 7'h50;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       enable = 1'b1;
    logic [6:0] device_address = DEV;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       scl_o, scl_t, sda_o, sda_t;
    logic       busy, bus_active, bus_addressed, last_rw;
    logic       scl_ctrl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       scl_line, sda_line;

    // Wired-AND open-drain bus.
    assign scl_line = scl_ctrl & (scl_t ? 1'b1 : scl_o);
    assign sda_line = sda_ctrl & (sda_t ? 1'b1 : sda_o);

    always #5 clk = ~clk;

    i2c_target #(.FILTER_LEN(FL)) dut (
        .clk               (clk),
        .arst_n            (arst_n),
        .enable            (enable),
        .device_address    (device_address),
        .m_axis_data_tdata (m_tdata),
        .m_axis_data_tvalid(m_tvalid),
        .m_axis_data_tready(m_tready),
        .s_axis_data_tdata (s_tdata),
        .s_axis_data_tvalid(s_tvalid),
        .s_axis_data_tready(s_tready),
        .scl_i             (scl_line),
        .scl_o             (scl_o),
        .scl_t             (scl_t),
        .sda_i             (sda_line),
        .sda_o             (sda_o),
        .sda_t             (sda_t)
        ,.busy             (busy),
        .bus_active        (bus_active),
        .bus_addressed     (bus_addressed),
        .last_rw           (last_rw)
    );

    // Read-data source: initial block fills src_mem, this side consumes.
    logic [7:0] src_mem [0:63];
    int         src_wr = 0;
    int         src_rd = 0;
    assign s_tvalid = (src_rd != src_wr);
    assign s_tdata  = src_mem[src_rd[5:0]];

    always @(posedge clk) begin
        if (s_tvalid && s_tready) src_rd <= src_rd + 1;
    end

    // Write-data sink.
    logic [7:0] rx_mem [0:63];
    int         rx_cnt = 0;
    always @(posedge clk) begin
        if (m_tvalid && m_tready) begin
            rx_mem[rx_cnt[5:0]] <= m_tdata;
            rx_cnt <= rx_cnt + 1;
        end
    end

    // Cycles in which the target pulls SDA low.
    int sda_low_cnt = 0;
    always @(posedge clk) begin
        if (!sda_t) sda_low_cnt <= sda_low_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int stretch_cnt = 0;
    logic [7:0] exp_mem [0:63];
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release SCL and wait (bounded) for it to actually go high.
    task automatic scl_up();
        int k;
        k = 0;
        scl_ctrl = 1'b1;
        while (scl_line !== 1'b1 && k < 5000) begin
            clks(1);
            k++;
        end
        stretch_cnt = k;
        if (scl_line !== 1'b1) chk("scl_release_timeout", 32'(scl_line), 32'd1);
    endtask

    task automatic write_bit(input logic b);
        sda_ctrl = b;
        clks(Q);
        scl_up();
        clks(2 * Q);
        scl_ctrl = 1'b0;
        clks(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_ctrl = 1'b1;
        clks(Q);
        scl_up();
        clks(Q);
        b = sda_line;
        clks(Q);
        scl_ctrl = 1'b0;
        clks(Q);
    endtask

    task automatic write_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        write_bits(d);
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic bus_start();
        sda_ctrl = 1'b0;
        clks(2 * Q);
        scl_ctrl = 1'b0;
        clks(Q);
    endtask

    task automatic bus_rstart();
        sda_ctrl = 1'b1;
        clks(Q);
        scl_up();
        clks(Q);
        sda_ctrl = 1'b0;
        clks(Q);
        scl_ctrl = 1'b0;
        clks(Q);
    endtask

    task automatic bus_stop();
        sda_ctrl = 1'b0;
        clks(Q);
        scl_up();
        clks(Q);
        sda_ctrl = 1'b1;
        clks(2 * Q);
    endtask

    task automatic expect_rx(input logic [7:0] d);
        exp_mem[exp_cnt[5:0]] = d;
        exp_cnt++;
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rx_count"}, 32'(rx_cnt), 32'(exp_cnt));
        for (int i = 0; i < exp_cnt && i < rx_cnt; i++)
            chk({tag, "_rx_byte"}, 32'(rx_mem[i]), 32'(exp_mem[i]));
    endtask

    task automatic push_src(input logic [7:0] d);
        src_mem[src_wr[5:0]] = d;
        src_wr++;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         base_low, base_rd;
        int         txn;
        txn = 0;

        // Reset state
        clks(3);
        chk("rst_scl_t", 32'(scl_t), 32'd1);
        chk("rst_sda_t", 32'(sda_t), 32'd1);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_active", 32'(bus_active), 32'd0);
        chk("rst_addressed", 32'(bus_addressed), 32'd0);
        chk("rst_last_rw", 32'(last_rw), 32'd0);
        arst_n = 1'b1;
        clks(20);

        // Write 0x50+W, A5, 3C
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        chk("wr_addr_ack", 32'(ack), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        write_byte(8'hA5, ack);
        chk("wr_d0_ack", 32'(ack), 32'd0);
        expect_rx(8'hA5);
        write_byte(8'h3C, ack);
        chk("wr_d1_ack", 32'(ack), 32'd0);
        expect_rx(8'h3C);
        chk("wr_active", 32'(bus_active), 32'd1);
        bus_stop();
        chk("wr_busy_after_stop", 32'(busy), 32'd0);
        chk("wr_active_after_stop", 32'(bus_active), 32'd0);
        check_rx("wr");
        $display("txn %0d: write 0x50 A5 3C done", txn++);

        // Foreign address 0x51
        base_low = sda_low_cnt;
        bus_start();
        write_byte(8'hA2, ack);
        chk("foreign_nack", 32'(ack), 32'd1);
        chk("foreign_addressed", 32'(bus_addressed), 32'd0);
        chk("foreign_active", 32'(bus_active), 32'd1);
        bus_stop();
        chk("foreign_sda_never_low", 32'(sda_low_cnt - base_low), 32'd0);
        chk("foreign_active_after_stop", 32'(bus_active), 32'd0);
        check_rx("foreign");
        $display("txn %0d: write to 0x51 ignored", txn++);

        // Read 5A (ACK) and C3 (NACK)
        base_rd = src_rd;
        push_src(8'h5A);
        push_src(8'hC3);
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        chk("rd_addr_ack", 32'(ack), 32'd0);
        chk("rd_last_rw", 32'(last_rw), 32'd1);
        read_byte(1'b0, rd);
        chk("rd_byte0", 32'(rd), 32'h5A);
        read_byte(1'b1, rd);
        chk("rd_byte1", 32'(rd), 32'hC3);
        chk("rd_sda_released_after_nack", 32'(sda_t), 32'd1);
        chk("rd_busy_before_stop", 32'(busy), 32'd1);
        bus_stop();
        chk("rd_tready_pulses", 32'(src_rd - base_rd), 32'd2);
        chk("rd_busy_after_stop", 32'(busy), 32'd0);
        $display("txn %0d: read 5A C3 done", txn++);

        // Stretch while the sink is stalled
        m_tready = 1'b0;
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        chk("st_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h96, ack);
        chk("st_d0_ack", 32'(ack), 32'd0);
        expect_rx(8'h96);
        write_bits(8'h69);
        fork
            read_bit(ack);
            begin
                clks(200);
                chk("st_scl_held", 32'(scl_t), 32'd0);
                chk("st_pending", 32'(m_tvalid), 32'd1);
                m_tready = 1'b1;
            end
        join
        chk("st_d1_ack", 32'(ack), 32'd0);
        chk("st_stretched", 32'(stretch_cnt > 100), 32'd1);
        expect_rx(8'h69);
        bus_stop();
        check_rx("st");
        $display("txn %0d: stretched write 96 69 done", txn++);

        // Write, repeated START, read
        push_src(8'h22);
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        chk("rs_wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h11, ack);
        chk("rs_wr_ack", 32'(ack), 32'd0);
        expect_rx(8'h11);
        bus_rstart();
        write_byte({DEV, 1'b1}, ack);
        chk("rs_rd_addr_ack", 32'(ack), 32'd0);
        read_byte(1'b1, rd);
        chk("rs_rd_byte", 32'(rd), 32'h22);
        bus_stop();
        check_rx("rs");
        $display("txn %0d: write 11, rstart, read 22 done", txn++);

        // Randomized transactions against the transaction model
        for (int t = 0; t < 8; t++) begin
            logic [6:0] addr;
            logic       rw, en, exp_ack;
            logic [7:0] data [0:3];
            int         n;
            addr = ($urandom_range(0, 3) != 0) ? DEV : 7'($urandom_range(0, 127));
            rw   = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 4) != 0);
            n    = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) data[i] = 8'($urandom);
            exp_ack = en && (addr == DEV);
            enable = en;
            if (exp_ack && rw) for (int i = 0; i < n; i++) push_src(data[i]);
            bus_start();
            write_byte({addr, rw}, ack);
            enable = 1'b1;
            chk("rnd_addr_ack", 32'(ack), 32'(!exp_ack));
            if (exp_ack) begin
                for (int i = 0; i < n; i++) begin
                    if (rw) begin
                        read_byte(i == n - 1, rd);
                        chk("rnd_rd_byte", 32'(rd), 32'(data[i]));
                    end else begin
                        write_byte(data[i], ack);
                        chk("rnd_wr_ack", 32'(ack), 32'd0);
                        expect_rx(data[i]);
                    end
                end
            end
            bus_stop();
            check_rx("rnd");
            $display("txn %0d: random addr=%02h rw=%0d en=%0d n=%0d acked=%0d",
                     txn++, addr, rw, en, n, exp_ack);
        end

        // Glitch on SDA shorter than the filter while SCL is high
        sda_ctrl = 1'b0;
        clks(FL - 1);
        sda_ctrl = 1'b1;
        clks(30);
        chk("glitch_no_start", 32'(bus_active), 32'd0);
        $display("txn %0d: SDA glitch ignored", txn++);

        // Reset in the middle of a read byte with a pending output byte
        m_tready = 1'b0;
        push_src(8'h00);
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        chk("rst_wr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h77, ack);
        bus_rstart();
        write_byte({DEV, 1'b1}, ack);
        chk("rst_rd_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) read_bit(ack);
        chk("rst_pre_sda_driven", 32'(sda_t), 32'd0);
        chk("rst_pre_pending", 32'(m_tvalid), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("rst_mid_sda_t", 32'(sda_t), 32'd1);
        chk("rst_mid_scl_t", 32'(scl_t), 32'd1);
        chk("rst_mid_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        clks(5);
        arst_n = 1'b1;
        m_tready = 1'b1;
        clks(20);
        check_rx("rst_mid");
        $display("txn %0d: reset mid-read, pending byte discarded", txn++);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Overall time bound in case the bus ever locks up.
    initial begin
        #20ms;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- 7-bit-address I2C target (slave) engine: the responder to the existing i2c_master.
- Decodes START, STOP and repeated START; matches its address; ACKs.
- Delivers written bytes on an AXI-stream master port and fetches read bytes from an AXI-stream slave port.
- Stretches SCL when the host side cannot keep up. Sits beside the register block so the system can also be addressed over the same bus.

Parameters:
- FILTER_LEN, 4: consecutive identical samples required before a filtered SCL/SDA value changes (range 1-15).

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  respond to address match when 1.
- device_address  in  7  own target address.
- m_axis_data_tdata  out  8  byte written by the bus controller.
- m_axis_data_tvalid  out  1  output byte valid.
- m_axis_data_tready  in  1  downstream accepts.
- s_axis_data_tdata  in  8  byte to return on a bus read.
- s_axis_data_tvalid  in  1  read byte available.
- s_axis_data_tready  out  1  read byte consumed (one-cycle pulse).
- scl_i  in  1  SCL pad input.
- scl_o  out  1  constant 0 (open-drain).
- scl_t  out  1  0 = pull SCL low (stretch), 1 = release.
- sda_i  in  1  SDA pad input.
- sda_o  out  1  constant 0 (open-drain).
- sda_t  out  1  0 = pull SDA low, 1 = release.
- busy  out  1  transaction addressed to this target in progress.
- bus_active  out  1  START seen, STOP not yet seen.
- bus_addressed  out  1  last address phase matched.
- last_rw  out  1  R/W bit of last matched address.

Behaviour:
- Reset: scl_t=1, sda_t=1, tvalid=0, tready=0, busy=0, bus_active=0, bus_addressed=0, last_rw=0, FSM=IDLE, filters preset to 1.
- Input path: 2-FF synchroniser, then glitch filter. Filtered-edge latency from the pad is 2+FILTER_LEN clk.
- START = filtered SDA falls while SCL is 1. STOP = SDA rises while SCL is 1. Both take priority over every other event in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_STRETCH, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state: go to ADDR, clear bit count, release SDA and SCL.
- STOP from any state: go to IDLE, busy=0, bus_active=0, release both lines.
- ADDR:
  - Shift SDA MSB-first on each SCL rise.
  - After the 8th bit: on match and enable=1, go to ADDR_ACK, set busy=1, bus_addressed=1, and latch last_rw.
  - Otherwise go to WAIT_STOP with bus_addressed=0.
- ADDR_ACK:
  - sda_t=0 from the next SCL fall until the following SCL fall.
  - Then go to WR_DATA if rw=0, or RD_LOAD if rw=1.
- WR_DATA:
  - Shift 8 bits on SCL rise.
  - On the SCL fall after bit 8: if the output register is free (tvalid=0, or tready=1 that cycle), load it, set tvalid=1, and go to WR_ACK.
  - Otherwise go to WR_STRETCH.
- WR_STRETCH: scl_t=0 until the output register frees, then load it, release SCL, and go to WR_ACK. ACK is always given.
- WR_ACK: sda_t=0 for one SCL low-high-low period, then back to WR_DATA.
- tvalid stays 1 until tready=1. A pending byte survives STOP and START.
- RD_LOAD:
  - SCL is low; scl_t=0 while s_axis_data_tvalid=0.
  - When tvalid=1: latch the byte, pulse tready for one cycle, release SCL, drive bit 7 immediately, and go to RD_DATA.
- RD_DATA: on each SCL fall, drive the next bit (sda_t = bit value). After the 8th bit's fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on SCL rise. 0 (ACK) goes to RD_LOAD on the next fall. 1 (NACK) goes to WAIT_STOP.
- WAIT_STOP: lines released; only START or STOP leave this state.
- enable is sampled only at the address-match decision. Deassertion mid-transaction has no effect.
- General call (0x00) and 10-bit addressing are not supported. 0x00 is treated as a normal address compare.
- Reset mid-transfer: all lines are released within one clk after arst_n falls (asynchronous). The pending output byte is discarded.

Decomposition:
- Package i2c_target_pkg holds the FSM state enum and the bit-count width constant (3 bits).
- Sub-module i2c_bus_monitor holds the synchroniser, the FILTER_LEN glitch filter, and the scl_rise, scl_fall, start and stop pulse generation. Its outputs are registered.

Test Plan:
- device_address=0x50, controller writes 0x50+W, 0xA5, 0x3C, STOP, tready=1: ACK on all 3 bytes; m_axis emits 0xA5 then 0x3C; busy falls after STOP.
- Controller addresses 0x51 (write): NACK; sda_t stays 1 throughout; no m_axis output; bus_addressed=0; bus_active=1 until STOP.
- Read 0x50+R, s_axis presents 0x5A then 0xC3, controller ACKs the first and NACKs the second: SDA carries 01011010 then 11000011; two tready pulses; WAIT_STOP, then IDLE on STOP.
- Write two bytes with tready=0 until 200 clk after the 2nd byte: SCL held low (scl_t=0) after the 2nd byte's 8th fall until the 1st byte is accepted; then ACK; order preserved.
- Write 0x50+W, 0x11, repeated START, 0x50+R, s_axis 0x22: 0x11 delivered; repeated START returns to ADDR; read returns 0x22.
- SDA glitch of FILTER_LEN-1 clk while SCL is high: no START/STOP detected. Assert arst_n=0 mid-byte: scl_t=sda_t=1 and tvalid=0 immediately.
